// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants for the program-counter generator.
//   - FSM state encodings (BOOT / RUN / HOLD)
//   - branch and chip-enable levels
//   - sequential step sizes
//   - dropped_bits(): reports whether target alignment discards set bits
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } pc_state_e;

    localparam logic BRANCH_ON    = 1'b1;
    localparam logic BRANCH_OFF   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [2:0] STEP_2 = 3'd2;
    localparam logic [2:0] STEP_4 = 3'd4;

    // With compressed support only bit 0 is forced low; otherwise bits 1:0.
    function automatic logic dropped_bits(input logic [1:0] low_bits, input logic c_ext);
        logic res;
        if (c_ext) begin
            res = low_bits[0];
        end else begin
            res = |low_bits;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: combinational redirect arbitration and target alignment.
// Ports:
//   flush, flush_target       - trap redirect request and target
//   branch, branch_target     - branch/jump redirect request and target
//   pend_valid, pend_flush,
//   pend_target               - currently latched redirect (from pc_gen)
//   sel_valid                 - some redirect (new or pending) is available
//   sel_target                - winning target, alignment bits cleared
//   sel_misalign              - winning target had non-zero cleared bits
//   pend_wr, pend_wr_flush,
//   pend_wr_target            - what the pending register should capture
//                               if the pipeline is stalled this cycle
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int C_EXT  = 0
) (
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_target,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              pend_valid,
    input  logic              pend_flush,
    input  logic [ADDR_W-1:0] pend_target,
    output logic              sel_valid,
    output logic [ADDR_W-1:0] sel_target,
    output logic              sel_misalign,
    output logic              pend_wr,
    output logic              pend_wr_flush,
    output logic [ADDR_W-1:0] pend_wr_target
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = (C_EXT != 0) ?
        {{(ADDR_W-1){1'b1}}, 1'b0} : {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [ADDR_W-1:0] raw_target_s;

    // Priority select: flush, then branch, then the latched redirect.
    always_comb begin
        sel_valid    = 1'b0;
        raw_target_s = {ADDR_W{1'b0}};
        if (flush) begin
            sel_valid    = 1'b1;
            raw_target_s = flush_target;
        end else if (branch == BRANCH_ON) begin
            sel_valid    = 1'b1;
            raw_target_s = branch_target;
        end else if (pend_valid) begin
            sel_valid    = 1'b1;
            raw_target_s = pend_target;
        end else begin
            sel_valid    = 1'b0;
            raw_target_s = {ADDR_W{1'b0}};
        end
    end

    // Alignment mask and dropped-bit detection on the winning target.
    always_comb begin
        sel_target   = raw_target_s & ALIGN_MASK;
        sel_misalign = sel_valid & dropped_bits(raw_target_s[1:0], (C_EXT != 0));
    end

    // Pending capture: a flush always overwrites; a branch never displaces a flush.
    always_comb begin
        pend_wr        = 1'b0;
        pend_wr_flush  = 1'b0;
        pend_wr_target = {ADDR_W{1'b0}};
        if (flush) begin
            pend_wr        = 1'b1;
            pend_wr_flush  = 1'b1;
            pend_wr_target = flush_target;
        end else if ((branch == BRANCH_ON) && !(pend_valid && pend_flush)) begin
            pend_wr        = 1'b1;
            pend_wr_flush  = 1'b0;
            pend_wr_target = branch_target;
        end else begin
            pend_wr        = 1'b0;
            pend_wr_flush  = 1'b0;
            pend_wr_target = {ADDR_W{1'b0}};
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: instruction fetch program-counter generator.
// Ports:
//   clk, rst (async, active-low)
//   flush_i / flush_target_i     - trap redirect (highest priority)
//   branch_flag_i / branch_target_i - branch/jump redirect
//   stall_i                      - pipeline stall, pc holds
//   inst_len16_i                 - current instruction is 16-bit (C_EXT=1 only)
//   fetch_ready_i                - instruction memory accepts pc
//   pc, ce, pc_valid_o           - registered fetch request
//   misalign_o                   - one-cycle pulse when a loaded target lost set bits
// Redirects seen while stalled are parked in a pending register (state HOLD)
// and applied on the first unstalled cycle.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}},
    parameter int                C_EXT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              stall_i,
    input  logic              inst_len16_i,
    input  logic              fetch_ready_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pc_valid_o,
    output logic              misalign_o
);

    pc_state_e         state_r, state_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic              ce_r, ce_nxt_s;
    logic              pc_valid_r, pc_valid_nxt_s;
    logic              misalign_r, misalign_nxt_s;
    logic              pend_valid_r, pend_valid_nxt_s;
    logic              pend_flush_r, pend_flush_nxt_s;
    logic [ADDR_W-1:0] pend_target_r, pend_target_nxt_s;

    logic [ADDR_W-1:0] step_s;
    logic              redirect_req_s;
    logic              handshake_s;
    logic              sel_valid_s;
    logic [ADDR_W-1:0] sel_target_s;
    logic              sel_misalign_s;
    logic              pend_wr_s;
    logic              pend_wr_flush_s;
    logic [ADDR_W-1:0] pend_wr_target_s;

    pc_redirect_arb #(
        .ADDR_W (ADDR_W),
        .C_EXT  (C_EXT)
    ) u_arb (
        .flush          (flush_i),
        .flush_target   (flush_target_i),
        .branch         (branch_flag_i),
        .branch_target  (branch_target_i),
        .pend_valid     (pend_valid_r),
        .pend_flush     (pend_flush_r),
        .pend_target    (pend_target_r),
        .sel_valid      (sel_valid_s),
        .sel_target     (sel_target_s),
        .sel_misalign   (sel_misalign_s),
        .pend_wr        (pend_wr_s),
        .pend_wr_flush  (pend_wr_flush_s),
        .pend_wr_target (pend_wr_target_s)
    );

    assign redirect_req_s = flush_i | (branch_flag_i == BRANCH_ON);
    assign handshake_s    = pc_valid_r & fetch_ready_i & ~stall_i;

    // Sequential step size: 2 only for a 16-bit instruction with compressed support.
    always_comb begin
        step_s = {{(ADDR_W-3){1'b0}}, STEP_4};
        if ((C_EXT != 0) && inst_len16_i) begin
            step_s = {{(ADDR_W-3){1'b0}}, STEP_2};
        end else begin
            step_s = {{(ADDR_W-3){1'b0}}, STEP_4};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (stall_i && redirect_req_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_BOOT;
        endcase
    end

    // FSM outputs: fetch request is live in every state except BOOT.
    always_comb begin
        ce_nxt_s       = CHIP_DISABLE;
        pc_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_RUN, ST_HOLD: begin
                ce_nxt_s       = CHIP_ENABLE;
                pc_valid_nxt_s = 1'b1;
            end
            default: begin
                ce_nxt_s       = CHIP_DISABLE;
                pc_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // PC, misalign pulse and pending-redirect next values.
    always_comb begin
        pc_nxt_s          = pc_r;
        misalign_nxt_s    = 1'b0;
        pend_valid_nxt_s  = pend_valid_r;
        pend_flush_nxt_s  = pend_flush_r;
        pend_target_nxt_s = pend_target_r;
        case (state_r)
            ST_BOOT: begin
                pc_nxt_s          = RESET_VEC;
                pend_valid_nxt_s  = 1'b0;
                pend_flush_nxt_s  = 1'b0;
                pend_target_nxt_s = {ADDR_W{1'b0}};
            end
            ST_RUN: begin
                if (stall_i) begin
                    if (pend_wr_s) begin
                        pend_valid_nxt_s  = 1'b1;
                        pend_flush_nxt_s  = pend_wr_flush_s;
                        pend_target_nxt_s = pend_wr_target_s;
                    end else begin
                        pend_valid_nxt_s  = pend_valid_r;
                    end
                end else if (sel_valid_s) begin
                    // A new redirect abandons the in-flight request.
                    pc_nxt_s       = sel_target_s;
                    misalign_nxt_s = sel_misalign_s;
                end else if (handshake_s) begin
                    pc_nxt_s = pc_r + step_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_HOLD: begin
                if (stall_i) begin
                    if (pend_wr_s) begin
                        pend_valid_nxt_s  = 1'b1;
                        pend_flush_nxt_s  = pend_wr_flush_s;
                        pend_target_nxt_s = pend_wr_target_s;
                    end else begin
                        pend_valid_nxt_s  = pend_valid_r;
                    end
                end else begin
                    pc_nxt_s          = sel_target_s;
                    misalign_nxt_s    = sel_misalign_s;
                    pend_valid_nxt_s  = 1'b0;
                    pend_flush_nxt_s  = 1'b0;
                    pend_target_nxt_s = {ADDR_W{1'b0}};
                end
            end
            default: begin
                pc_nxt_s         = RESET_VEC;
                pend_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset discards any pending redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r          <= RESET_VEC;
            ce_r          <= CHIP_DISABLE;
            pc_valid_r    <= 1'b0;
            misalign_r    <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_flush_r  <= 1'b0;
            pend_target_r <= {ADDR_W{1'b0}};
        end else begin
            pc_r          <= pc_nxt_s;
            ce_r          <= ce_nxt_s;
            pc_valid_r    <= pc_valid_nxt_s;
            misalign_r    <= misalign_nxt_s;
            pend_valid_r  <= pend_valid_nxt_s;
            pend_flush_r  <= pend_flush_nxt_s;
            pend_target_r <= pend_target_nxt_s;
        end
    end

    assign pc         = pc_r;
    assign ce         = ce_r;
    assign pc_valid_o = pc_valid_r;
    assign misalign_o = misalign_r;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed testbench for pc_gen. Two instances share stimulus:
// u_dut0 (C_EXT=0, RESET_VEC=0x80000000) and u_dut1 (C_EXT=1, RESET_VEC=0).
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_target_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        stall_i;
    logic        inst_len16_i;
    logic        fetch_ready_i;

    logic [31:0] pc0, pc1;
    logic        ce0, ce1;
    logic        valid0, valid1;
    logic        mis0, mis1;

    int errors = 0;
    int checks = 0;

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h8000_0000), .C_EXT(0)) u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .flush_target_i  (flush_target_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .inst_len16_i    (inst_len16_i),
        .fetch_ready_i   (fetch_ready_i),
        .pc              (pc0),
        .ce              (ce0),
        .pc_valid_o      (valid0),
        .misalign_o      (mis0)
    );

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0000_0000), .C_EXT(1)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .flush_target_i  (flush_target_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .inst_len16_i    (inst_len16_i),
        .fetch_ready_i   (fetch_ready_i),
        .pc              (pc1),
        .ce              (ce1),
        .pc_valid_o      (valid1),
        .misalign_o      (mis1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        flush_i         = 1'b0;
        flush_target_i  = 32'h0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        stall_i         = 1'b0;
        inst_len16_i    = 1'b0;
        fetch_ready_i   = 1'b1;
        #1 rst = 1'b0;
        #2;
        // Reset state
        check("rst_pc",    pc0, 32'h8000_0000);
        check("rst_ce",    {31'd0, ce0}, 32'd0);
        check("rst_valid", {31'd0, valid0}, 32'd0);
        check("rst_mis",   {31'd0, mis0}, 32'd0);

        // Boot and sequential fetch
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("boot_ce",    {31'd0, ce0}, 32'd1);
        check("boot_valid", {31'd0, valid0}, 32'd1);
        check("boot_pc",    pc0, 32'h8000_0000);
        tick();
        check("seq_pc1", pc0, 32'h8000_0004);
        tick();
        check("seq_pc2", pc0, 32'h8000_0008);

        // Wrap at top of address space
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        tick();
        branch_flag_i = 1'b0;
        check("wrap_load", pc0, 32'hFFFF_FFFC);
        check("wrap_mis",  {31'd0, mis0}, 32'd0);
        tick();
        check("wrap_pc", pc0, 32'h0000_0000);

        // Memory not ready: pc holds
        branch_flag_i = 1'b1; branch_target_i = 32'h10;
        tick();
        branch_flag_i = 1'b0;
        fetch_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("notready_hold", pc0, 32'h10);
        end
        fetch_ready_i = 1'b1;
        tick();
        check("ready_adv", pc0, 32'h14);

        // Stalled branch, later flush overrides, later branch does not
        branch_flag_i = 1'b1; branch_target_i = 32'h40;
        tick();
        check("br_40", pc0, 32'h40);
        stall_i = 1'b1; branch_target_i = 32'h200;
        tick();
        branch_flag_i = 1'b0;
        check("hold_pc_a", pc0, 32'h40);
        check("hold_valid", {31'd0, valid0}, 32'd1);
        tick();
        check("hold_pc_b", pc0, 32'h40);
        flush_i = 1'b1; flush_target_i = 32'h300;
        tick();
        flush_i = 1'b0;
        check("hold_pc_c", pc0, 32'h40);
        branch_flag_i = 1'b1; branch_target_i = 32'h600;
        tick();
        branch_flag_i = 1'b0;
        check("hold_pc_d", pc0, 32'h40);
        stall_i = 1'b0;
        tick();
        check("hold_release", pc0, 32'h300);
        tick();
        check("after_release", pc0, 32'h304);

        // Simultaneous flush and branch
        flush_i = 1'b1; flush_target_i = 32'h700;
        branch_flag_i = 1'b1; branch_target_i = 32'h800;
        tick();
        flush_i = 1'b0; branch_flag_i = 1'b0;
        check("flush_wins", pc0, 32'h700);

        // Redirect ignores fetch_ready
        fetch_ready_i = 1'b0;
        branch_flag_i = 1'b1; branch_target_i = 32'h900;
        tick();
        branch_flag_i = 1'b0;
        check("br_noready", pc0, 32'h900);
        fetch_ready_i = 1'b1;

        // Alignment with and without compressed support
        branch_flag_i = 1'b1; branch_target_i = 32'h1236;
        tick();
        branch_flag_i = 1'b0;
        check("align_pc0",  pc0, 32'h1234);
        check("align_mis0", {31'd0, mis0}, 32'd1);
        check("align_pc1",  pc1, 32'h1236);
        check("align_mis1", {31'd0, mis1}, 32'd0);
        inst_len16_i = 1'b1;
        tick();
        check("step_pc0",    pc0, 32'h1238);
        check("mis0_pulse",  {31'd0, mis0}, 32'd0);
        check("step16_pc1",  pc1, 32'h1238);
        inst_len16_i = 1'b0;

        // Reset during HOLD drops the pending redirect
        stall_i = 1'b1;
        branch_flag_i = 1'b1; branch_target_i = 32'h500;
        tick();
        branch_flag_i = 1'b0;
        check("hold2_pc", pc0, 32'h1238);
        #2 rst = 1'b0;
        #1;
        check("async_pc", pc0, 32'h8000_0000);
        check("async_ce", {31'd0, ce0}, 32'd0);
        @(negedge clk);
        stall_i = 1'b0;
        rst = 1'b1;
        tick();
        check("reboot_pc", pc0, 32'h8000_0000);
        check("reboot_ce", {31'd0, ce0}, 32'd1);
        tick();
        check("reboot_seq", pc0, 32'h8000_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, setting the PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h00000000, setting the first fetch address after reset.
REQ-003 SHALL have parameter C_EXT, default 0; value 1 selects 2-byte instruction alignment and variable step.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have port flush_i  input  1  trap/exception redirect request.
REQ-007 SHALL have port flush_target_i  input  ADDR_W  trap target address.
REQ-008 SHALL have port branch_flag_i  input  1  branch/jump redirect request.
REQ-009 SHALL have port branch_target_i  input  ADDR_W  branch target address.
REQ-010 SHALL have port stall_i  input  1  pipeline stall; PC holds while high.
REQ-011 SHALL have port inst_len16_i  input  1  current instruction is 16-bit; ignored when C_EXT=0.
REQ-012 SHALL have port fetch_ready_i  input  1  instruction memory accepts the presented PC.
REQ-013 SHALL have port pc  output  ADDR_W  current fetch address (registered).
REQ-014 SHALL have port ce  output  1  instruction memory chip enable (registered).
REQ-015 SHALL have port pc_valid_o  output  1  pc is a valid fetch request (registered).
REQ-016 SHALL have port misalign_o  output  1  one-cycle pulse: an accepted redirect target had non-zero dropped bits.

Function
REQ-017 SHALL implement FSM states BOOT, RUN, HOLD, with encodings defined as constants.
REQ-018 BOOT: ce=0, pc_valid_o=0, pc=RESET_VEC; SHALL go to RUN on the first clock edge after rst deasserts, setting ce=1 and pc_valid_o=1 with pc still RESET_VEC.
REQ-019 RUN: a handshake completes when pc_valid_o & fetch_ready_i & !stall_i; only then SHALL pc advance by the step.
REQ-020 Step SHALL be 4 when C_EXT=0; when C_EXT=1, 2 if inst_len16_i else 4.
REQ-021 Increment SHALL be modulo 2^ADDR_W (max address + step wraps to low addresses, no flag).
REQ-022 Redirect priority SHALL be flush_i > branch_flag_i > pending redirect > sequential increment.
REQ-023 flush_i or branch_flag_i SHALL load the target on the next edge regardless of fetch_ready_i; the in-flight request is abandoned.
REQ-024 A redirect arriving while stall_i=1 SHALL be latched into a pending register; state SHALL go RUN->HOLD and pc SHALL hold.
REQ-025 HOLD: a later flush_i SHALL overwrite the pending target; a later branch_flag_i SHALL NOT overwrite a pending flush.
REQ-026 HOLD: on the first cycle with stall_i=0, pc SHALL load the pending target, the pending register SHALL clear, and state SHALL return to RUN.
REQ-027 Target alignment: bit 0 SHALL always be cleared; bit 1 SHALL also be cleared when C_EXT=0.
REQ-028 misalign_o SHALL pulse for one cycle in the cycle pc loads a target whose cleared bits were non-zero.
REQ-029 pc_valid_o SHALL remain 1 in RUN and HOLD; in HOLD the memory sees the held pc, so no new handshake completes.
REQ-030 Simultaneous flush_i and branch_flag_i SHALL take flush_target_i only.

Reset
REQ-031 On rst low, the block SHALL asynchronously force state=BOOT, pc=RESET_VEC, ce=0, pc_valid_o=0, misalign_o=0, and clear the pending register.
REQ-032 Reset asserted mid-operation, including in HOLD, SHALL discard any pending redirect; no redirect SHALL survive reset.

Structure
REQ-033 FSM state encodings, Branch/ChipEnable/ChipDisable levels and step constants SHALL live in the shared defines.v.
REQ-034 Priority selection and alignment masking SHALL be one combinational sub-module, pc_redirect_arb; pc_gen holds all registers and the FSM.

Verification
REQ-035 Reset release, fetch_ready_i=1, RESET_VEC=32'h80000000 -> ce 0->1; pc sequence 80000000, 80000004, 80000008.
REQ-036 fetch_ready_i=0 for 3 cycles at pc=0x10 -> pc holds 0x10; then advances to 0x14 one edge after ready=1.
REQ-037 stall_i=1 with branch to 0x200 at pc=0x40, then flush to 0x300 two cycles later, stall released -> pc=0x300 next edge, not 0x200.
REQ-038 C_EXT=0, branch_target_i=0x1236 -> pc=0x1234, misalign_o pulses 1 cycle; C_EXT=1, same target -> pc=0x1236, no pulse; inst_len16_i=1 -> next pc 0x1238.
REQ-039 pc=0xFFFFFFFC, ADDR_W=32, handshake completes -> pc=0x00000000.
REQ-040 rst pulsed low mid-HOLD with pending target 0x500 -> pc=RESET_VEC and ce=0 immediately (async); after release, fetch starts at RESET_VEC, never 0x500.
